// File: rtl/dcache_nway_pkg.sv
// Shared types and widths for the N-way set-associative write-back D-cache.
package dcache_nway_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_FILL = 2'd2
  } state_e;

  localparam int unsigned LINE_W         = 128;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned WORD_SEL_W     = 2;
  localparam int unsigned ADDR_W         = 30;
  localparam int unsigned LINE_ADDR_W    = ADDR_W - WORD_SEL_W;

  // Memory-side request payload.
  typedef struct packed {
    logic                   rd;
    logic                   wr;
    logic [LINE_ADDR_W-1:0] addr;
    logic [LINE_W-1:0]      data;
  } mem_req_t;

  // Extract one 32-bit word from a line.
  function automatic logic [WORD_W-1:0] get_word(input logic [LINE_W-1:0]     line,
                                                 input logic [WORD_SEL_W-1:0] sel);
    return line[{sel, 5'd0} +: WORD_W];
  endfunction

  // Replace one 32-bit word within a line.
  function automatic logic [LINE_W-1:0] put_word(input logic [LINE_W-1:0]     line,
                                                 input logic [WORD_SEL_W-1:0] sel,
                                                 input logic [WORD_W-1:0]     word);
    logic [LINE_W-1:0] res;
    res = line;
    res[{sel, 5'd0} +: WORD_W] = word;
    return res;
  endfunction

endpackage

// File: rtl/dcache_lru_set.sv
// Victim selection and true-LRU age update for the ways of one set.
module dcache_lru_set
  import dcache_nway_pkg::*;
#(
  parameter int unsigned WAY_BITS = 1,
  localparam int unsigned NWAYS   = 1 << WAY_BITS,
  localparam int unsigned IW      = (WAY_BITS > 0) ? WAY_BITS : 1
) (
  input  logic [NWAYS-1:0]         valid_i,
  input  logic [NWAYS-1:0][IW-1:0] age_i,
  input  logic [IW-1:0]            access_i,
  output logic [IW-1:0]            victim_c,
  output logic [NWAYS-1:0][IW-1:0] age_c
);

  logic inval_found;

  // Victim: lowest-index invalid way first, otherwise the oldest way.
  always_comb begin
    victim_c    = '0;
    inval_found = 1'b0;
    for (int w = 0; w < NWAYS; w++) begin
      if (!valid_i[w] && !inval_found) begin
        victim_c    = IW'(w);
        inval_found = 1'b1;
      end
    end
    if (!inval_found) begin
      for (int w = 0; w < NWAYS; w++) begin
        if (age_i[w] == IW'(NWAYS - 1)) victim_c = IW'(w);
      end
    end
  end

  // Ages after accessing access_i: younger ways age by one, accessed way becomes 0.
  always_comb begin
    age_c = age_i;
    for (int w = 0; w < NWAYS; w++) begin
      if (IW'(w) == access_i) begin
        age_c[w] = '0;
      end else if (age_i[w] < age_i[access_i]) begin
        age_c[w] = age_i[w] + IW'(1);
      end
    end
  end

endmodule

// File: rtl/dcache_nway.sv
// Parametrised N-way set-associative write-back data cache with LRU and hit/miss counters.
module dcache_nway
  import dcache_nway_pkg::*;
#(
  parameter int unsigned SET_BITS = 2,
  parameter int unsigned WAY_BITS = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   proc_reset,
  input  logic                   proc_read,
  input  logic                   proc_write,
  input  logic [ADDR_W-1:0]      proc_addr,
  input  logic [WORD_W-1:0]      proc_wdata,
  output logic [WORD_W-1:0]      proc_rdata,
  output logic                   proc_stall,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [LINE_ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0]      mem_wdata,
  input  logic [LINE_W-1:0]      mem_rdata,
  input  logic                   mem_ready
);

  localparam int unsigned NSETS = 1 << SET_BITS;
  localparam int unsigned NWAYS = 1 << WAY_BITS;
  localparam int unsigned TAG_W = LINE_ADDR_W - SET_BITS;
  localparam int unsigned IW    = (WAY_BITS > 0) ? WAY_BITS : 1;

  state_e state_q, state_d;
  logic [NSETS-1:0][NWAYS-1:0]             valid_q, valid_d;
  logic [NSETS-1:0][NWAYS-1:0]             dirty_q, dirty_d;
  logic [NSETS-1:0][NWAYS-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [NSETS-1:0][NWAYS-1:0][LINE_W-1:0] data_q, data_d;
  logic [NSETS-1:0][NWAYS-1:0][IW-1:0]     age_q, age_d;
  logic [IW-1:0]                           victim_q, victim_d;
  logic [CNT_W-1:0]                        hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]                        miss_cnt_q, miss_cnt_d;

  logic                    rd_op, wr_op;
  logic [SET_BITS-1:0]     set_idx;
  logic [TAG_W-1:0]        tag_in;
  logic [WORD_SEL_W-1:0]   word_sel;
  logic                    hit_c;
  logic [IW-1:0]           hit_way_c;
  logic [IW-1:0]           lru_access_c;
  logic [IW-1:0]           victim_c;
  logic [NWAYS-1:0][IW-1:0] age_next_c;
  logic                    stall_c;
  logic [WORD_W-1:0]       rdata_c;
  logic [LINE_W-1:0]       fill_line_c;
  mem_req_t                mem_req_c;

  assign rd_op    = proc_read & ~proc_write;
  assign wr_op    = proc_write & ~proc_read;
  assign set_idx  = proc_addr[SET_BITS+1:2];
  assign tag_in   = proc_addr[ADDR_W-1:SET_BITS+2];
  assign word_sel = proc_addr[WORD_SEL_W-1:0];

  // Tag compare across the ways of the indexed set.
  always_comb begin
    hit_c     = 1'b0;
    hit_way_c = '0;
    for (int w = 0; w < NWAYS; w++) begin
      if (valid_q[set_idx][w] && (tag_q[set_idx][w] == tag_in)) begin
        hit_c     = 1'b1;
        hit_way_c = IW'(w);
      end
    end
  end

  assign lru_access_c = (state_q == ST_FILL) ? victim_q : hit_way_c;

  dcache_lru_set #(
    .WAY_BITS (WAY_BITS)
  ) u_lru (
    .valid_i  (valid_q[set_idx]),
    .age_i    (age_q[set_idx]),
    .access_i (lru_access_c),
    .victim_c (victim_c),
    .age_c    (age_next_c)
  );

  // Next-state, array update and output decode for the miss-handling FSM.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    tag_d       = tag_q;
    data_d      = data_q;
    age_d       = age_q;
    victim_d    = victim_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    stall_c     = 1'b0;
    rdata_c     = '0;
    fill_line_c = mem_rdata;
    mem_req_c   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (rd_op || wr_op) begin
          if (hit_c) begin
            if (rd_op) begin
              rdata_c = get_word(data_q[set_idx][hit_way_c], word_sel);
            end else begin
              data_d[set_idx][hit_way_c]  = put_word(data_q[set_idx][hit_way_c], word_sel, proc_wdata);
              dirty_d[set_idx][hit_way_c] = 1'b1;
            end
            age_d[set_idx] = age_next_c;
            hit_cnt_d      = (&hit_cnt_q) ? hit_cnt_q : hit_cnt_q + CNT_W'(1);
          end else begin
            stall_c    = 1'b1;
            victim_d   = victim_c;
            miss_cnt_d = (&miss_cnt_q) ? miss_cnt_q : miss_cnt_q + CNT_W'(1);
            state_d    = dirty_q[set_idx][victim_c] ? ST_WB : ST_FILL;
          end
        end
      end
      ST_WB: begin
        stall_c        = 1'b1;
        mem_req_c.wr   = 1'b1;
        mem_req_c.addr = {tag_q[set_idx][victim_q], set_idx};
        mem_req_c.data = data_q[set_idx][victim_q];
        if (mem_ready) begin
          dirty_d[set_idx][victim_q] = 1'b0;
          state_d                    = ST_FILL;
        end
      end
      ST_FILL: begin
        stall_c        = 1'b1;
        mem_req_c.rd   = 1'b1;
        mem_req_c.addr = {tag_in, set_idx};
        if (mem_ready) begin
          stall_c = 1'b0;
          if (wr_op) begin
            fill_line_c = put_word(mem_rdata, word_sel, proc_wdata);
          end else begin
            rdata_c = get_word(mem_rdata, word_sel);
          end
          data_d[set_idx][victim_q]  = fill_line_c;
          tag_d[set_idx][victim_q]   = tag_in;
          valid_d[set_idx][victim_q] = 1'b1;
          dirty_d[set_idx][victim_q] = wr_op;
          age_d[set_idx]             = age_next_c;
          state_d                    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign proc_stall = stall_c;
  assign proc_rdata = rdata_c;
  assign mem_read   = mem_req_c.rd;
  assign mem_write  = mem_req_c.wr;
  assign mem_addr   = mem_req_c.addr;
  assign mem_wdata  = mem_req_c.data;

  // State, array and counter registers; reset restores ages to age[w]=w.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q    <= ST_IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      tag_q      <= '0;
      data_q     <= '0;
      victim_q   <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int s = 0; s < NSETS; s++) begin
        for (int w = 0; w < NWAYS; w++) begin
          age_q[s][w] <= IW'(w);
        end
      end
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
      age_q      <= age_d;
      victim_q   <= victim_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_dcache_nway.sv
// Self-checking bench for dcache_nway: scripted scenarios plus randomized traffic against a recency-list model.
module tb_dcache_nway;

  localparam int SET_BITS = 2;
  localparam int WAY_BITS = 1;
  localparam int CNT_W    = 4;
  localparam int NSETS    = 1 << SET_BITS;
  localparam int NWAYS    = 1 << WAY_BITS;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic         clk = 1'b0;
  logic         proc_reset = 1'b1;
  logic         proc_read = 1'b0;
  logic         proc_write = 1'b0;
  logic [29:0]  proc_addr = '0;
  logic [31:0]  proc_wdata = '0;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;

  dcache_nway #(
    .SET_BITS (SET_BITS),
    .WAY_BITS (WAY_BITS),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Expectations for the current cycle, set by the driver after each rising edge.
  logic         chk_en = 1'b0;
  logic         chk_zero = 1'b0;
  logic         chk_rdata = 1'b0;
  logic         exp_stall = 1'b0;
  logic         exp_mrd = 1'b0;
  logic         exp_mwr = 1'b0;
  logic [27:0]  exp_maddr = '0;
  logic [127:0] exp_mwdata = '0;
  logic [31:0]  exp_rdata = '0;

  // Last values seen on the DUT outputs, for literal checks.
  logic [27:0]  obs_wb_addr = '0;
  logic [127:0] obs_wb_data = '0;
  logic [27:0]  obs_fill_addr = '0;
  logic [31:0]  obs_rdata = '0;

  // Model: per-way contents plus a recency list per set (index 0 = most recent).
  logic         m_valid [NSETS][NWAYS];
  logic         m_dirty [NSETS][NWAYS];
  logic [27:0]  m_laddr [NSETS][NWAYS];
  logic [127:0] m_data  [NSETS][NWAYS];
  int           ord     [NSETS][NWAYS];
  int           m_hits;
  int           m_misses;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process: checks every enabled cycle on the falling edge.
  always @(negedge clk) begin
    if (mem_write) begin
      obs_wb_addr = mem_addr;
      obs_wb_data = mem_wdata;
    end
    if (mem_read) obs_fill_addr = mem_addr;
    if (proc_read && !proc_write && !proc_stall) obs_rdata = proc_rdata;
    if (chk_en) begin
      chk("proc_stall", 128'(proc_stall), 128'(exp_stall));
      chk("mem_read", 128'(mem_read), 128'(exp_mrd));
      chk("mem_write", 128'(mem_write), 128'(exp_mwr));
      if (exp_mrd || exp_mwr) chk("mem_addr", 128'(mem_addr), 128'(exp_maddr));
      if (exp_mwr) chk("mem_wdata", mem_wdata, exp_mwdata);
      if (chk_rdata) chk("proc_rdata", 128'(proc_rdata), 128'(exp_rdata));
      if (chk_zero) begin
        chk("rst_rdata", 128'(proc_rdata), 128'(0));
        chk("rst_maddr", 128'(mem_addr), 128'(0));
        chk("rst_mwdata", mem_wdata, 128'(0));
      end
      chk("hit_cnt", 128'(dut.hit_cnt_q), 128'(m_hits));
      chk("miss_cnt", 128'(dut.miss_cnt_q), 128'(m_misses));
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int s = 0; s < NSETS; s++) begin
      for (int w = 0; w < NWAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_laddr[s][w] = '0;
        m_data[s][w]  = '0;
        ord[s][w]     = w;
      end
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic touch(input int s, input int w);
    int p;
    p = 0;
    for (int k = 0; k < NWAYS; k++) if (ord[s][k] == w) p = k;
    for (int k = p; k > 0; k--) ord[s][k] = ord[s][k-1];
    ord[s][0] = w;
  endtask

  function automatic logic [31:0] word_of(input logic [127:0] line, input int ws);
    return line[ws*32 +: 32];
  endfunction

  // One core request from issue to completion; wlat/flat are WB/FILL cycle counts incl. the ready cycle.
  task automatic do_op(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] wd,
                       input int wlat, input int flat, input logic [127:0] fl);
    int s, ws, hw, v;
    logic [127:0] ln;
    s  = int'(a[SET_BITS+1:2]);
    ws = int'(a[1:0]);
    proc_read  = rd;
    proc_write = wr;
    proc_addr  = a;
    proc_wdata = wd;
    mem_ready  = 1'($urandom_range(0, 1));
    exp_mrd    = 1'b0;
    exp_mwr    = 1'b0;
    chk_rdata  = 1'b0;
    exp_stall  = 1'b0;
    if (rd == wr) begin
      next();
      return;
    end
    hw = -1;
    for (int w = 0; w < NWAYS; w++) if (m_valid[s][w] && m_laddr[s][w] == a[29:2]) hw = w;
    if (hw >= 0) begin
      ln        = m_data[s][hw];
      chk_rdata = rd;
      exp_rdata = word_of(ln, ws);
      next();
      if (wr) begin
        ln[ws*32 +: 32] = wd;
        m_data[s][hw]   = ln;
        m_dirty[s][hw]  = 1'b1;
      end
      touch(s, hw);
      if (m_hits < CNT_MAX) m_hits++;
      return;
    end
    v = -1;
    for (int w = 0; w < NWAYS; w++) if (!m_valid[s][w] && v < 0) v = w;
    if (v < 0) v = ord[s][NWAYS-1];
    exp_stall = 1'b1;
    next();
    if (m_misses < CNT_MAX) m_misses++;
    if (m_dirty[s][v]) begin
      for (int i = 0; i < wlat; i++) begin
        exp_mwr    = 1'b1;
        exp_maddr  = m_laddr[s][v];
        exp_mwdata = m_data[s][v];
        mem_ready  = (i == wlat - 1);
        next();
      end
      m_dirty[s][v] = 1'b0;
      exp_mwr       = 1'b0;
    end
    for (int i = 0; i < flat; i++) begin
      exp_mrd   = 1'b1;
      exp_maddr = a[29:2];
      mem_ready = (i == flat - 1);
      mem_rdata = (i == flat - 1) ? fl : {4{$urandom}};
      exp_stall = (i != flat - 1);
      chk_rdata = rd && (i == flat - 1);
      exp_rdata = word_of(fl, ws);
      next();
    end
    ln = fl;
    if (wr) ln[ws*32 +: 32] = wd;
    m_data[s][v]  = ln;
    m_laddr[s][v] = a[29:2];
    m_valid[s][v] = 1'b1;
    m_dirty[s][v] = wr;
    touch(s, v);
    exp_mrd   = 1'b0;
    exp_stall = 1'b0;
    chk_rdata = 1'b0;
    mem_ready = 1'b0;
  endtask

  // Read to the empty set 1, then reset on the 3rd FILL cycle.
  task automatic reset_mid_fill();
    proc_read  = 1'b1;
    proc_write = 1'b0;
    proc_addr  = 30'h1234;
    mem_ready  = 1'b0;
    exp_stall  = 1'b1;
    exp_mrd    = 1'b0;
    exp_mwr    = 1'b0;
    chk_rdata  = 1'b0;
    next();
    if (m_misses < CNT_MAX) m_misses++;
    exp_mrd   = 1'b1;
    exp_maddr = 28'h48D;
    next();
    next();
    proc_reset = 1'b1;
    next();
    model_reset();
    proc_reset = 1'b0;
    proc_read  = 1'b0;
    mem_ready  = 1'b1;
    exp_mrd    = 1'b0;
    exp_stall  = 1'b0;
    next();
    mem_ready = 1'b0;
    chk("valid_cleared", 128'(dut.valid_q), 128'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [29:0] a;
    int op;
    logic [127:0] w2;
    model_reset();
    next();
    next();
    proc_reset = 1'b0;
    chk_en     = 1'b1;
    chk_zero   = 1'b1;
    next();
    chk_zero = 1'b0;

    // Cold read miss, then hit on the same line.
    obs_rdata = '0;
    do_op(1'b1, 1'b0, 30'h10, 32'h0, 1, 3, {32'h44444444, 32'h33333333, 32'h22222222, 32'hDEADBEEF});
    chk("t1_fill_addr", 128'(obs_fill_addr), 128'(28'h4));
    chk("t1_rdata", 128'(obs_rdata), 128'(32'hDEADBEEF));
    obs_rdata = '0;
    do_op(1'b1, 1'b0, 30'h10, 32'h0, 1, 1, '0);
    chk("t1_hit_rdata", 128'(obs_rdata), 128'(32'hDEADBEEF));
    chk("t1_hit_cnt", 128'(dut.hit_cnt_q), 128'(1));
    chk("t1_miss_cnt", 128'(dut.miss_cnt_q), 128'(1));

    // Dirty eviction in set 0 with a long write-back.
    do_op(1'b0, 1'b1, 30'h2, 32'h11111111, 1, 2, {4{32'hA5A5A5A5}});
    do_op(1'b1, 1'b0, 30'h42, 32'h0, 1, 2, {4{32'h5A5A5A5A}});
    do_op(1'b1, 1'b0, 30'h82, 32'h0, 11, 3, {4{32'h0F0F0F0F}});
    w2 = obs_wb_data;
    chk("t2_wb_addr", 128'(obs_wb_addr), 128'(28'h0));
    chk("t2_wb_word2", 128'(w2[95:64]), 128'(32'h11111111));
    chk("t2_fill_addr", 128'(obs_fill_addr), 128'(28'h20));

    // Both request lines high is a no-op.
    do_op(1'b1, 1'b1, 30'h300, 32'h0, 1, 1, '0);
    chk("t6_hit_cnt", 128'(dut.hit_cnt_q), 128'(1));
    chk("t6_miss_cnt", 128'(dut.miss_cnt_q), 128'(4));

    reset_mid_fill();
    do_op(1'b1, 1'b0, 30'h10, 32'h0, 1, 2, {4{$urandom}});
    chk("t5_miss_after_rst", 128'(dut.miss_cnt_q), 128'(1));

    // Randomized traffic over a small address pool to force conflicts and saturation.
    for (int i = 0; i < 400; i++) begin
      a  = {26'($urandom_range(0, 5)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      op = $urandom_range(0, 9);
      do_op(op < 5, (op >= 5 && op < 9) || op == 9, a, $urandom,
            $urandom_range(1, 4), $urandom_range(1, 4), {$urandom, $urandom, $urandom, $urandom});
    end

    proc_read  = 1'b0;
    proc_write = 1'b0;
    next();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
